// File: rtl/clock_set_controller_pkg.sv
// Shared definitions for the desk clock time-setting front-end: FSM state
// encodings, default timing parameters and a helper that classifies the two
// debounced button levels.
package clock_set_controller_pkg;

   // Time-setting FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_BOTH   = 2'd3
   } set_state_e;

   // How many of the two debounced levels are high.
   typedef enum logic [1:0] {
      MIX_NONE   = 2'd0,
      MIX_SINGLE = 2'd1,
      MIX_BOTH   = 2'd2
   } btn_mix_e;

   localparam int DEFAULT_DEBOUNCE_SAMPLES = 4;
   localparam int DEFAULT_HOLD_TICKS       = 8;

   // Collapse the two debounced levels into none / single / both.
   function automatic btn_mix_e classify_levels(input logic hours, input logic minutes);
      case ({hours, minutes})
         2'b00:   return MIX_NONE;
         2'b11:   return MIX_BOTH;
         default: return MIX_SINGLE;
      endcase
   endfunction

endpackage : clock_set_controller_pkg

// File: rtl/clock_set_controller_button_debounce.sv
// One push-button conditioner: a 2-flop synchronizer followed by a sample
// counter that only changes the debounced level after SAMPLES consecutive
// debounce ticks disagree with it.
module button_debounce #(
   parameter int SAMPLES = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sample_stb,
   input  logic i_btn_raw,
   output logic o_level
);

   localparam int CNT_W = $clog2(SAMPLES + 1);

   if (SAMPLES < 1) begin : g_bad_samples
      $error("button_debounce: SAMPLES must be >= 1");
   end

   // sync_q[0] is the metastability catcher, sync_q[1] the synchronized value.
   logic [1:0]       sync_q, sync_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_inc;

   // One extra bit so the compare against SAMPLES can never wrap.
   assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

   // Next-state logic for the synchronizer, the sample counter and the level.
   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      sync_d  = {sync_q[0], i_btn_raw};
      level_d = level_q;
      cnt_d   = cnt_q;
      if (i_sample_stb) begin
         if (sync_q[1] == level_q) begin
            cnt_d = '0;
         end else if (cnt_inc == (CNT_W + 1)'(SAMPLES)) begin
            level_d = ~level_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
         end
      end
   end

   // Register all debounce state; synchronous reset clears everything.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      if (i_reset) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_level = level_q;

endmodule : button_debounce

// File: rtl/clock_set_controller.sv
// Time-setting front-end for the desk clock. Debounces the hours and minutes
// buttons, then turns the levels into single-cycle increment strobes: one on
// press, then auto-repeat after HOLD_TICKS repeat ticks. Both buttons together
// give both levels and no strobe (seconds clear) until both are released.
// Repeat ticks are assumed to be at least two cycles apart, as a ~4 Hz tick is.
module clock_set_controller
   import clock_set_controller_pkg::*;
#(
   parameter int DEBOUNCE_SAMPLES = DEFAULT_DEBOUNCE_SAMPLES,
   parameter int HOLD_TICKS       = DEFAULT_HOLD_TICKS
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_debounce_stb,
   input  logic i_repeat_stb,
   input  logic i_btn_hours,
   input  logic i_btn_minutes,
   output logic o_set_hours,
   output logic o_set_minutes,
   output logic o_set_stb
);

   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   if (HOLD_TICKS < 1) begin : g_bad_hold_ticks
      $error("clock_set_controller: HOLD_TICKS must be >= 1");
   end

   logic set_hours;
   logic set_minutes;

   button_debounce #(
      .SAMPLES (DEBOUNCE_SAMPLES)
   ) u_debounce_hours (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_sample_stb (i_debounce_stb),
      .i_btn_raw    (i_btn_hours),
      .o_level      (set_hours)
   );

   button_debounce #(
      .SAMPLES (DEBOUNCE_SAMPLES)
   ) u_debounce_minutes (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_sample_stb (i_debounce_stb),
      .i_btn_raw    (i_btn_minutes),
      .o_level      (set_minutes)
   );

   set_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [HOLD_W:0]   hold_inc;
   logic              hold_done;
   logic              stb_q, stb_d;
   btn_mix_e          mix;

   assign mix       = classify_levels(set_hours, set_minutes);
   assign hold_inc  = {1'b0, hold_cnt_q} + (HOLD_W + 1)'(1);
   // This repeat tick is the one that completes the hold period.
   assign hold_done = i_repeat_stb && (hold_inc >= (HOLD_W + 1)'(HOLD_TICKS));

   // State register plus hold counter and strobe flop; reset aborts any hold.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
         stb_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         stb_q      <= stb_d;
      end
   end

   // Next-state logic: a release always wins, any both-high cycle goes to BOTH.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (mix == MIX_BOTH) begin
               state_d = ST_BOTH;
            end else if (mix == MIX_SINGLE) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (mix == MIX_NONE) begin
               state_d = ST_IDLE;
            end else if (mix == MIX_BOTH) begin
               state_d = ST_BOTH;
            end else if (hold_done) begin
               state_d = ST_REPEAT;
            end
         end
         ST_REPEAT: begin
            if (mix == MIX_NONE) begin
               state_d = ST_IDLE;
            end else if (mix == MIX_BOTH) begin
               state_d = ST_BOTH;
            end
         end
         ST_BOTH: begin
            // Dropping to one button must not restart a hold after a seconds clear.
            if (mix == MIX_NONE) begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   // Output logic: strobe request (registered one cycle later) and hold counter.
   always_comb begin
      stb_d      = 1'b0;
      hold_cnt_d = hold_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            // A repeat tick seen here is deliberately not counted.
            hold_cnt_d = '0;
            if (mix == MIX_SINGLE) begin
               stb_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (mix != MIX_SINGLE) begin
               hold_cnt_d = '0;
            end else if (hold_done) begin
               stb_d      = 1'b1;
               hold_cnt_d = HOLD_W'(HOLD_TICKS);
            end else if (i_repeat_stb) begin
               hold_cnt_d = hold_inc[HOLD_W-1:0];
            end
         end
         ST_REPEAT: begin
            if (mix != MIX_SINGLE) begin
               hold_cnt_d = '0;
            end else if (i_repeat_stb) begin
               stb_d = 1'b1;
            end
         end
         ST_BOTH: begin
            hold_cnt_d = '0;
         end
      endcase
   end

   assign o_set_hours   = set_hours;
   assign o_set_minutes = set_minutes;
   assign o_set_stb     = stb_q;

endmodule : clock_set_controller
